// File: rtl/agen_split_stage.sv
// Address-generation output stage: adds displacement to the SIB address, registers the
// linear address toward memory, and splits 8-byte-line-crossing accesses into two pieces.
module agen_split_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      sib_addr,
  input  logic [31:0]      disp,
  input  logic             disp_en,
  input  logic [1:0]       opsize,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [7:0]       out_be,
  output logic             out_first,
  output logic             out_last,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    SPLIT1 = 2'd2
  } state_t;

  state_t state, state_n;

  logic             valid_n;
  logic [31:0]      addr_n;
  logic [7:0]       be_n;
  logic             first_n, last_n;
  logic [TAG_W-1:0] tag_n;
  logic [31:0]      sec_addr, sec_addr_n;
  logic [7:0]       sec_be, sec_be_n;

  logic [31:0] lin;
  logic [3:0]  size;
  logic [2:0]  off;
  logic [3:0]  end_pos;
  logic        split;
  logic [7:0]  size_mask;
  logic [7:0]  be_single, be_first, be_second;
  logic [2:0]  sec_sh;
  logic [31:0] next_line;
  logic        accept;

  // Address arithmetic and piece encoding for the incoming access
  always_comb begin
    lin       = sib_addr + (disp_en ? disp : 32'd0);
    size      = 4'd1 << opsize;
    off       = lin[2:0];
    end_pos   = 4'(off) + size;
    split     = (end_pos > 4'd8);
    case (opsize)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    be_single = size_mask << off;
    be_first  = 8'hFF << off;
    sec_sh    = 3'(end_pos - 4'd8);
    be_second = (8'd1 << sec_sh) - 8'd1;
    next_line = {lin[31:3] + 29'd1, 3'b000};
  end

  assign in_ready = (state == EMPTY) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    valid_n    = out_valid;
    addr_n     = out_addr;
    be_n       = out_be;
    first_n    = out_first;
    last_n     = out_last;
    tag_n      = out_tag;
    sec_addr_n = sec_addr;
    sec_be_n   = sec_be;

    if (flush) begin
      state_n = EMPTY;
      valid_n = 1'b0;
    end else begin
      case (state)
        SPLIT1: begin
          if (out_ready) begin
            state_n = HOLD;
            addr_n  = sec_addr;
            be_n    = sec_be;
            first_n = 1'b0;
            last_n  = 1'b1;
          end
        end
        HOLD: begin
          if (out_ready && !accept) begin
            state_n = EMPTY;
            valid_n = 1'b0;
          end
        end
        default: ;
      endcase

      // Load a new access; only reachable from EMPTY or a draining HOLD
      if (accept) begin
        state_n    = split ? SPLIT1 : HOLD;
        valid_n    = 1'b1;
        addr_n     = lin;
        be_n       = split ? be_first : be_single;
        first_n    = 1'b1;
        last_n     = !split;
        tag_n      = in_tag;
        sec_addr_n = next_line;
        sec_be_n   = be_second;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_addr  <= 32'd0;
      out_be    <= 8'd0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_tag   <= '0;
      sec_addr  <= 32'd0;
      sec_be    <= 8'd0;
    end else begin
      state     <= state_n;
      out_valid <= valid_n;
      out_addr  <= addr_n;
      out_be    <= be_n;
      out_first <= first_n;
      out_last  <= last_n;
      out_tag   <= tag_n;
      sec_addr  <= sec_addr_n;
      sec_be    <= sec_be_n;
    end
  end

endmodule

// File: tb/tb_agen_split_stage.sv
// Directed bench for agen_split_stage: single, split, wrap, backpressure, flush and async reset.
module tb_agen_split_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sib_addr;
  logic [31:0] disp;
  logic        disp_en;
  logic [1:0]  opsize;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [7:0]  out_be;
  logic        out_first;
  logic        out_last;
  logic [3:0]  out_tag;

  int checks   = 0;
  int failures = 0;

  agen_split_stage #(.TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sib_addr  (sib_addr),
    .disp      (disp),
    .disp_en   (disp_en),
    .opsize    (opsize),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_be    (out_be),
    .out_first (out_first),
    .out_last  (out_last),
    .out_tag   (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares {valid, addr, be, first, last, tag} as one word
  task automatic expect_out(input string tag, input logic v, input logic [31:0] a,
                            input logic [7:0] b, input logic f, input logic l,
                            input logic [3:0] t);
    check(tag, 64'({out_valid, out_addr, out_be, out_first, out_last, out_tag}),
          64'({v, a, b, f, l, t}));
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic de, input logic [1:0] sz, input logic [3:0] t);
    in_valid = v;
    sib_addr = a;
    disp     = d;
    disp_en  = de;
    opsize   = sz;
    in_tag   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_outs", 1'b0, 32'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    #1;
    check("reset_rdy", 64'(in_ready), 64'(1));

    // Single access with displacement
    drive(1'b1, 32'hAA05_FA00, 32'h0000_0010, 1'b1, 2'b10, 4'd3);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("single", 1'b1, 32'hAA05_FA10, 8'h0F, 1'b1, 1'b1, 4'd3);
    step();
    expect_out("single_drain", 1'b0, 32'hAA05_FA10, 8'h0F, 1'b1, 1'b1, 4'd3);

    // Split, disp ignored because disp_en = 0
    drive(1'b1, 32'h0000_AA06, 32'hDEAD_0000, 1'b0, 2'b10, 4'd5);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("split_p1", 1'b1, 32'h0000_AA06, 8'hC0, 1'b1, 1'b0, 4'd5);
    check("split_rdy", 64'(in_ready), 64'(0));
    step();
    expect_out("split_p2", 1'b1, 32'h0000_AA08, 8'h03, 1'b0, 1'b1, 4'd5);
    step();
    check("split_done", 64'(out_valid), 64'(0));

    // Wrap of the second-piece line address
    drive(1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0, 2'b11, 4'd7);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("wrap_p1", 1'b1, 32'hFFFF_FFFC, 8'hF0, 1'b1, 1'b0, 4'd7);
    step();
    expect_out("wrap_p2", 1'b1, 32'h0000_0000, 8'h0F, 1'b0, 1'b1, 4'd7);
    step();

    // Displacement carry dropped, then back-to-back singles
    drive(1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1, 2'b00, 4'd1);
    step();
    expect_out("disp_wrap", 1'b1, 32'h0000_0000, 8'h01, 1'b1, 1'b1, 4'd1);
    drive(1'b1, 32'h0000_1002, 32'h0000_0001, 1'b1, 2'b01, 4'd2);
    #1;
    check("b2b_rdy", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("b2b_second", 1'b1, 32'h0000_1003, 8'h18, 1'b1, 1'b1, 4'd2);
    step();

    // Backpressure in HOLD with a pending input
    drive(1'b1, 32'h0000_0100, 32'd0, 1'b0, 2'b01, 4'd9);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0203, 32'd0, 1'b0, 2'b00, 4'd10);
    #1;
    expect_out("bp_c", 1'b1, 32'h0000_0100, 8'h03, 1'b1, 1'b1, 4'd9);
    check("bp_rdy0", 64'(in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("bp_stable", 1'b1, 32'h0000_0100, 8'h03, 1'b1, 1'b1, 4'd9);
      check("bp_rdy", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("bp_d", 1'b1, 32'h0000_0203, 8'h08, 1'b1, 1'b1, 4'd10);
    step();

    // Flush in SPLIT1 with a coinciding input
    drive(1'b1, 32'h0000_0007, 32'd0, 1'b0, 2'b01, 4'd4);
    step();
    expect_out("fl_p1", 1'b1, 32'h0000_0007, 8'h80, 1'b1, 1'b0, 4'd4);
    flush = 1'b1;
    drive(1'b1, 32'h0000_0300, 32'd0, 1'b0, 2'b00, 4'd6);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    check("fl_valid", 64'(out_valid), 64'(0));
    check("fl_rdy", 64'(in_ready), 64'(1));
    step();
    check("fl_no_p2", 64'(out_valid), 64'(0));

    // Async reset mid-cycle during SPLIT1
    drive(1'b1, 32'h0000_001E, 32'd0, 1'b0, 2'b10, 4'd8);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    out_ready = 1'b0;
    expect_out("rst_p1", 1'b1, 32'h0000_001E, 8'hC0, 1'b1, 1'b0, 4'd8);
    #2;
    reset = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 32'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0040, 32'd0, 1'b0, 2'b11, 4'd12);
    #1;
    check("rst_rdy", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 4'd0);
    expect_out("rst_after", 1'b1, 32'h0000_0040, 8'hFF, 1'b1, 1'b1, 4'd12);
    step();
    check("rst_no_residue", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agen_split_stage.md
Name: agen_split_stage

Overview:
- Pipeline stage directly downstream of the SIB/ModRM effective-address generator.
- Takes the segment-adjusted SIB address, adds the instruction displacement and registers the resulting linear address toward the memory stage.
- Splits any access that crosses an 8-byte memory line into two sequential line-aligned requests with byte enables.
- Uses a valid/ready handshake on both sides and supports a synchronous pipeline flush.

Parameters:
TAG_W, 4, width of the instruction tag carried alongside each access.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous pipeline flush; discards any held access.
in_valid  input  1  upstream access presented.
in_ready  output  1  stage can accept an access this cycle.
sib_addr  input  32  segment-adjusted address from the SIB generator.
disp  input  32  displacement, already sign-extended to 32 bits.
disp_en  input  1  1 = add disp; 0 = add nothing.
opsize  input  2  access size: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B.
in_tag  input  TAG_W  instruction tag.
out_valid  output  1  registered memory request valid.
out_ready  input  1  memory stage accepts the request.
out_addr  output  32  request address.
out_be  output  8  byte enables within the 8-byte line.
out_first  output  1  request is the first (or only) piece.
out_last  output  1  request is the last (or only) piece.
out_tag  output  TAG_W  tag of the held access.

Behaviour:
- Address arithmetic:
  - lin = sib_addr + (disp_en ? disp : 0), modulo 2^32; the carry is dropped.
  - size = 1/2/4/8 from opsize; off = lin[2:0]; split when off + size > 8.
- Piece encoding:
  - Single access: addr = lin; be = ((1<<size)-1) << off; first = 1; last = 1.
  - Split, first piece: addr = lin; be = 0xFF << off, truncated to 8 bits; first = 1; last = 0.
  - Split, second piece: addr = {lin[31:3]+1, 3'b000} modulo 2^32, so 0xFFFF_FFF8 wraps to 0; be = (1 << (off+size-8)) - 1; first = 0; last = 1.
  - Split-piece values are computed at acceptance and held in registers.
- States: EMPTY, HOLD (holding the single piece or the last piece), SPLIT1 (holding the first piece, second piece pending).
- in_ready is combinational:
  - 1 in EMPTY;
  - in HOLD, equal to out_ready;
  - 0 in SPLIT1.
- An access is accepted when in_valid & in_ready. It appears on the outputs the next cycle: 1-cycle latency, no combinational in-to-out path.
- Transitions, in priority order:
  - reset (asynchronous): EMPTY.
  - flush: EMPTY. The held piece and any pending second piece are dropped, and the input is not accepted in that cycle even if in_valid = 1.
  - EMPTY: on accept, go to SPLIT1 if split, else HOLD; otherwise stay.
  - HOLD, out_ready = 1: on accept, load the new access (HOLD or SPLIT1); with no accept, go to EMPTY.
  - HOLD, out_ready = 0: hold all outputs stable.
  - SPLIT1, out_ready = 1: load the second piece, go to HOLD.
  - SPLIT1, out_ready = 0: hold.
- out_valid = 1 in HOLD and SPLIT1, 0 in EMPTY.
- While out_valid & !out_ready, out_addr, out_be, out_first, out_last and out_tag must not change. The tag is the same on both pieces.
- Reset values: out_valid = 0, out_addr = 0, out_be = 0, out_first = 0, out_last = 0, out_tag = 0. in_ready = 1 once reset is low.
- Reset asserted mid-split drops both pieces; no residue remains after release.
- Back-to-back single accesses with out_ready held high sustain one request per cycle.

Test Plan:
- Single access: sib_addr = AA05_FA00, disp = 0000_0010, disp_en = 1, opsize = 10 -> next cycle out_addr = AA05_FA10, out_be = 0F, out_first = 1, out_last = 1.
- Split: sib_addr = 0000_AA06, disp_en = 0, opsize = 10, out_ready = 1:
  - cycle 1: out_addr = 0000_AA06, out_be = C0, out_first = 1, out_last = 0, in_ready = 0;
  - cycle 2: out_addr = 0000_AA08, out_be = 03, out_first = 0, out_last = 1.
- Wrap: sib_addr = FFFF_FFFC, opsize = 11 -> first piece FFFF_FFFC with out_be = F0, then 0000_0000 with out_be = 0F. Also, sib_addr = 0000_0010 with disp = FFFF_FFF0 -> out_addr = 0000_0000.
- Backpressure: out_ready = 0 for 3 cycles while in HOLD -> all outputs stable and in_ready = 0. On release, a pending in_valid is accepted the same cycle and output one cycle later.
- Flush in SPLIT1 -> next cycle out_valid = 0 and in_ready = 1; the second piece is never issued. A flush coinciding with in_valid = 1 does not accept that input.
- Asynchronous reset pulse mid-cycle during SPLIT1 -> out_valid = 0 and all outputs 0 immediately. The first access after release produces a correct single piece.
